alu_rs: RTL and testbench

- Reservation station for the integer ALU. Sits directly downstream of dispatch and upstream of the ALU functional unit.
- Buffers renamed uops in NUM_ENTRIES slots and wakes source operands on CDB broadcasts.
- Issues one ready uop per cycle to the ALU, lowest ready slot index first.

---
 rtl/rv32i_types.sv | 35 +++
 rtl/alu_rs_if.sv | 68 ++++++
 rtl/alu_rs_pick.sv | 22 ++
 rtl/alu_rs.sv | 136 +++++++++++++
 tb/tb_alu_rs.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I backend types: register/ROB sizing and the
// ALU reservation-station entry layout.
package rv32i_types;
  localparam int PHYS_REG_IDX    = 5;
  localparam int ARCH_REG_IDX    = 4;
  localparam int NUM_ROB_ENTRIES = 16;
  localparam int ROB_IDX_W       = $clog2(NUM_ROB_ENTRIES);
  localparam int RV_XLEN         = 32;

  typedef logic [PHYS_REG_IDX:0] preg_t;
  typedef logic [ARCH_REG_IDX:0] areg_t;
  typedef logic [ROB_IDX_W-1:0]  rob_idx_t;

  typedef struct packed {
    logic               valid;
    preg_t              ps1;
    preg_t              ps2;
    logic               rdy1;
    logic               rdy2;
    logic [RV_XLEN-1:0] imm;
    logic [3:0]         op;
    preg_t              pd;
    areg_t              rd;
    rob_idx_t           rob_idx;
    logic               dest_we;
    logic [31:0]        pc;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
  } alu_rs_entry_t;

  // p0 is hard-wired, so a broadcast of tag 0 never wakes anything
  function automatic logic tag_hit(logic v, preg_t bc, preg_t tag);
    return v && (bc != '0) && (bc == tag);
  endfunction
endpackage

// File: rtl/alu_rs_if.sv
// Dispatch-enqueue, CDB and ALU-issue bundle of the ALU
// reservation station; master drives enq/cdb, slave is the RS.
interface alu_rs_if #(
  parameter int XLEN = 32
);
  import rv32i_types::*;

  logic        enq_valid;
  logic        enq_ready;
  preg_t       enq_ps1;
  preg_t       enq_ps2;
  logic        enq_rs1_rdy;
  logic        enq_rs2_rdy;
  logic [XLEN-1:0] enq_imm;
  logic [3:0]  enq_op;
  preg_t       enq_pd;
  areg_t       enq_rd;
  rob_idx_t    enq_rob_idx;
  logic        enq_dest_we;
  logic [31:0] enq_pc;
  logic [6:0]  enq_opcode;
  logic [2:0]  enq_funct3;

  logic        cdb_valid;
  preg_t       cdb_pd;

  logic        iss_valid;
  logic        iss_ready;
  preg_t       iss_ps1;
  preg_t       iss_ps2;
  logic [XLEN-1:0] iss_imm;
  logic [3:0]  iss_op;
  preg_t       iss_pd;
  areg_t       iss_rd;
  rob_idx_t    iss_rob_idx;
  logic        iss_dest_we;
  logic [31:0] iss_pc;
  logic [6:0]  iss_opcode;
  logic [2:0]  iss_funct3;

  modport master (
    output enq_valid, enq_ps1, enq_ps2,
    output enq_rs1_rdy, enq_rs2_rdy,
    output enq_imm, enq_op, enq_pd, enq_rd,
    output enq_rob_idx, enq_dest_we,
    output enq_pc, enq_opcode, enq_funct3,
    output cdb_valid, cdb_pd, iss_ready,
    input  enq_ready, iss_valid,
    input  iss_ps1, iss_ps2, iss_imm, iss_op,
    input  iss_pd, iss_rd, iss_rob_idx,
    input  iss_dest_we, iss_pc, iss_opcode,
    input  iss_funct3
  );

  modport slave (
    input  enq_valid, enq_ps1, enq_ps2,
    input  enq_rs1_rdy, enq_rs2_rdy,
    input  enq_imm, enq_op, enq_pd, enq_rd,
    input  enq_rob_idx, enq_dest_we,
    input  enq_pc, enq_opcode, enq_funct3,
    input  cdb_valid, cdb_pd, iss_ready,
    output enq_ready, iss_valid,
    output iss_ps1, iss_ps2, iss_imm, iss_op,
    output iss_pd, iss_rd, iss_rob_idx,
    output iss_dest_we, iss_pc, iss_opcode,
    output iss_funct3
  );
endinterface

// File: rtl/alu_rs_pick.sv
// Parameterised lowest-index priority encoder used for the
// free-slot and ready-slot picks of the reservation station.
module rs_pick_lowest #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);
  localparam int W = $clog2(N);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = W'(i);
      end
    end
  end
endmodule

// File: rtl/alu_rs.sv
// Integer ALU reservation station: CDB wakeup, lowest-slot issue.
// Optional ALU_RS_FLUSH_EN adds a flush port that squashes all slots.
module alu_rs
  import rv32i_types::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int XLEN        = 32
) (
  input logic clk,
  input logic rst,
`ifdef ALU_RS_FLUSH_EN
  input logic flush,
`endif
  alu_rs_if.slave io
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int OCC_W = IDX_W + 1;

  alu_rs_entry_t slots [NUM_ENTRIES];
  alu_rs_entry_t new_ent;

  logic [OCC_W-1:0]       occ;
  logic [NUM_ENTRIES-1:0] free_vec;
  logic [NUM_ENTRIES-1:0] rdy_vec;
  logic                   free_found;
  logic                   rdy_found;
  logic [IDX_W-1:0]       free_idx;
  logic [IDX_W-1:0]       rdy_idx;
  logic                   squash;
  logic                   has_room;
  logic                   enq_fire;
  logic                   iss_fire;

`ifdef ALU_RS_FLUSH_EN
  assign squash = flush;
`else
  assign squash = 1'b0;
`endif

  always_comb begin
    free_vec = '0;
    rdy_vec  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      free_vec[i] = !slots[i].valid;
      rdy_vec[i]  = slots[i].valid
                  & slots[i].rdy1
                  & slots[i].rdy2;
    end
  end

  rs_pick_lowest #(.N(NUM_ENTRIES)) u_free (
    .req   (free_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_pick_lowest #(.N(NUM_ENTRIES)) u_rdy (
    .req   (rdy_vec),
    .found (rdy_found),
    .idx   (rdy_idx)
  );

  assign has_room     = occ < OCC_W'(NUM_ENTRIES);
  assign io.enq_ready = has_room && !squash;
  assign io.iss_valid = rdy_found && !squash;
  assign enq_fire     = io.enq_valid && io.enq_ready;
  assign iss_fire     = io.iss_valid && io.iss_ready;

  // operands broadcast in the enqueue cycle are captured here
  always_comb begin
    new_ent         = '0;
    new_ent.valid   = 1'b1;
    new_ent.ps1     = io.enq_ps1;
    new_ent.ps2     = io.enq_ps2;
    new_ent.rdy1    = io.enq_rs1_rdy || (io.enq_ps1 == '0)
                   || tag_hit(io.cdb_valid, io.cdb_pd, io.enq_ps1);
    new_ent.rdy2    = io.enq_rs2_rdy || (io.enq_ps2 == '0)
                   || tag_hit(io.cdb_valid, io.cdb_pd, io.enq_ps2);
    new_ent.imm     = io.enq_imm;
    new_ent.op      = io.enq_op;
    new_ent.pd      = io.enq_pd;
    new_ent.rd      = io.enq_rd;
    new_ent.rob_idx = io.enq_rob_idx;
    new_ent.dest_we = io.enq_dest_we;
    new_ent.pc      = io.enq_pc;
    new_ent.opcode  = io.enq_opcode;
    new_ent.funct3  = io.enq_funct3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) slots[i] <= '0;
      occ <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (tag_hit(io.cdb_valid, io.cdb_pd, slots[i].ps1))
          slots[i].rdy1 <= 1'b1;
        if (tag_hit(io.cdb_valid, io.cdb_pd, slots[i].ps2))
          slots[i].rdy2 <= 1'b1;
        if (squash)
          slots[i].valid <= 1'b0;
        else if (iss_fire && IDX_W'(i) == rdy_idx)
          slots[i].valid <= 1'b0;
        else if (enq_fire && IDX_W'(i) == free_idx)
          slots[i] <= new_ent;
      end
      unique case (1'b1)
        squash:                occ <= '0;
        enq_fire && !iss_fire: occ <= occ + OCC_W'(1);
        iss_fire && !enq_fire: occ <= occ - OCC_W'(1);
        default:               ;
      endcase
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(iss_fire && !enq_fire && occ == '0));
      assert (!(enq_fire && !iss_fire
                && occ == OCC_W'(NUM_ENTRIES)));
      assert (has_room == free_found);
    end
  end

  assign io.iss_ps1     = io.iss_valid ? slots[rdy_idx].ps1 : '0;
  assign io.iss_ps2     = io.iss_valid ? slots[rdy_idx].ps2 : '0;
  assign io.iss_imm     = io.iss_valid ? slots[rdy_idx].imm : '0;
  assign io.iss_op      = io.iss_valid ? slots[rdy_idx].op : '0;
  assign io.iss_pd      = io.iss_valid ? slots[rdy_idx].pd : '0;
  assign io.iss_rd      = io.iss_valid ? slots[rdy_idx].rd : '0;
  assign io.iss_rob_idx = io.iss_valid ? slots[rdy_idx].rob_idx : '0;
  assign io.iss_dest_we = io.iss_valid ? slots[rdy_idx].dest_we : '0;
  assign io.iss_pc      = io.iss_valid ? slots[rdy_idx].pc : '0;
  assign io.iss_opcode  = io.iss_valid ? slots[rdy_idx].opcode : '0;
  assign io.iss_funct3  = io.iss_valid ? slots[rdy_idx].funct3 : '0;
endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus random
// traffic against a slot-array reference model.
module tb_alu_rs;
  localparam int N = 8;

  typedef struct {
    bit          v;
    logic [5:0]  ps1, ps2;
    bit          r1, r2;
    logic [31:0] imm;
    logic [3:0]  op;
    logic [5:0]  pd;
    logic [4:0]  rd;
    logic [3:0]  rob;
    logic        we;
    logic [31:0] pc;
    logic [6:0]  opc;
    logic [2:0]  f3;
  } mslot_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int checks = 0;
  int errors = 0;
  mslot_t m [N];

  always #5 clk = ~clk;

  alu_rs_if #(.XLEN(32)) io ();

  alu_rs #(.NUM_ENTRIES(N), .XLEN(32)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef ALU_RS_FLUSH_EN
    .flush (flush),
`endif
    .io    (io)
  );

  task automatic check(string tag, logic [127:0] got,
                       logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack_m(mslot_t s);
    return {s.ps1, s.ps2, s.imm, s.op, s.pd, s.rd, s.rob,
            s.we, s.pc, s.opc, s.f3};
  endfunction

  function automatic logic [127:0] pack_dut();
    return {io.iss_ps1, io.iss_ps2, io.iss_imm, io.iss_op,
            io.iss_pd, io.iss_rd, io.iss_rob_idx,
            io.iss_dest_we, io.iss_pc, io.iss_opcode,
            io.iss_funct3};
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (m[i].v) c++;
    return c;
  endfunction

  function automatic int m_ready_idx();
    for (int i = 0; i < N; i++)
      if (m[i].v && m[i].r1 && m[i].r2) return i;
    return -1;
  endfunction

  function automatic int m_free_idx();
    for (int i = 0; i < N; i++) if (!m[i].v) return i;
    return -1;
  endfunction

  task automatic compare_all();
    int ri = m_ready_idx();
    mslot_t z = '{default: 0};
    check("enq_ready", io.enq_ready, m_count() < N);
    check("iss_valid", io.iss_valid, ri >= 0);
    check("iss_fields", pack_dut(),
          ri >= 0 ? pack_m(m[ri]) : pack_m(z));
  endtask

  task automatic tick();
    bit fl, wake, efire, ifire;
    int fi, ri;
    logic [5:0] bc;
    fl    = 1'b0;
`ifdef ALU_RS_FLUSH_EN
    fl    = flush;
`endif
    fi    = m_free_idx();
    ri    = m_ready_idx();
    bc    = io.cdb_pd;
    wake  = io.cdb_valid && bc != 0;
    efire = io.enq_valid && fi >= 0 && !fl;
    ifire = io.iss_ready && ri >= 0 && !fl;
    for (int i = 0; i < N; i++) begin
      if (m[i].v && wake && m[i].ps1 == bc) m[i].r1 = 1;
      if (m[i].v && wake && m[i].ps2 == bc) m[i].r2 = 1;
    end
    if (ifire) m[ri].v = 0;
    if (efire) begin
      m[fi].v   = 1;
      m[fi].ps1 = io.enq_ps1;
      m[fi].ps2 = io.enq_ps2;
      m[fi].r1  = io.enq_rs1_rdy || io.enq_ps1 == 0
               || (wake && bc == io.enq_ps1);
      m[fi].r2  = io.enq_rs2_rdy || io.enq_ps2 == 0
               || (wake && bc == io.enq_ps2);
      m[fi].imm = io.enq_imm;
      m[fi].op  = io.enq_op;
      m[fi].pd  = io.enq_pd;
      m[fi].rd  = io.enq_rd;
      m[fi].rob = io.enq_rob_idx;
      m[fi].we  = io.enq_dest_we;
      m[fi].pc  = io.enq_pc;
      m[fi].opc = io.enq_opcode;
      m[fi].f3  = io.enq_funct3;
    end
    if (fl) for (int i = 0; i < N; i++) m[i].v = 0;
    @(posedge clk);
    #1;
    io.enq_valid = 1'b0;
    io.cdb_valid = 1'b0;
    flush        = 1'b0;
    compare_all();
  endtask

  task automatic drive_enq(int ps1, bit r1, int ps2, bit r2,
                           int pd, int rob);
    io.enq_valid   = 1'b1;
    io.enq_ps1     = 6'(ps1);
    io.enq_rs1_rdy = r1;
    io.enq_ps2     = 6'(ps2);
    io.enq_rs2_rdy = r2;
    io.enq_pd      = 6'(pd);
    io.enq_rob_idx = 4'(rob);
    io.enq_imm     = $urandom;
    io.enq_op      = 4'($urandom);
    io.enq_rd      = 5'($urandom);
    io.enq_dest_we = 1'($urandom);
    io.enq_pc      = $urandom;
    io.enq_opcode  = 7'($urandom);
    io.enq_funct3  = 3'($urandom);
  endtask

  task automatic cdb(int tag);
    io.cdb_valid = 1'b1;
    io.cdb_pd    = 6'(tag);
  endtask

  task automatic drain();
    io.iss_ready = 1'b1;
    for (int k = 0; k < 40 && m_count() != 0; k++) begin
      for (int i = 0; i < N; i++) begin
        if (m[i].v && !(m[i].r1 && m[i].r2)) begin
          cdb(!m[i].r1 ? int'(m[i].ps1) : int'(m[i].ps2));
          break;
        end
      end
      tick();
    end
    check("drain_timeout", m_count(), 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) m[i] = '{default: 0};
    rst = 1'b1;
    flush = 1'b0;
    io.enq_valid = 0; io.enq_ps1 = 0; io.enq_ps2 = 0;
    io.enq_rs1_rdy = 0; io.enq_rs2_rdy = 0; io.enq_imm = 0;
    io.enq_op = 0; io.enq_pd = 0; io.enq_rd = 0;
    io.enq_rob_idx = 0; io.enq_dest_we = 0; io.enq_pc = 0;
    io.enq_opcode = 0; io.enq_funct3 = 0;
    io.cdb_valid = 0; io.cdb_pd = 0; io.iss_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_enq_ready", io.enq_ready, 1);
    check("rst_iss_valid", io.iss_valid, 0);
    check("rst_iss_fields", pack_dut(), 0);
    rst = 1'b0;

    // basic issue and free
    io.iss_ready = 1'b1;
    drive_enq(5, 1, 6, 1, 10, 3);
    tick();
    check("t1_valid", io.iss_valid, 1);
    check("t1_pd", io.iss_pd, 10);
    check("t1_rob", io.iss_rob_idx, 3);
    tick();
    check("t1_freed", io.iss_valid, 0);

    // wakeup two cycles after enqueue
    drive_enq(7, 0, 8, 1, 11, 4);
    tick();
    check("t2_wait", io.iss_valid, 0);
    tick();
    cdb(7);
    tick();
    check("t2_wake", io.iss_valid, 1);
    check("t2_pd", io.iss_pd, 11);
    tick();

    // same-cycle capture
    drive_enq(3, 1, 9, 0, 12, 5);
    cdb(9);
    tick();
    check("t3_capture", io.iss_valid, 1);
    check("t3_pd", io.iss_pd, 12);
    tick();

    // fill, reject, free one
    for (int i = 0; i < N; i++) begin
      drive_enq(20 + i, 0, 1, 1, 40 + i, i);
      tick();
    end
    check("t4_full", io.enq_ready, 0);
    drive_enq(3, 1, 4, 1, 63, 15);
    tick();
    check("t4_ninth", io.iss_valid, 0);
    cdb(22);
    tick();
    check("t4_slot2", io.iss_pd, 42);
    check("t4_still_full", io.enq_ready, 0);
    tick();
    check("t4_room", io.enq_ready, 1);
    drain();

    // hold under backpressure, then in order
    io.iss_ready = 1'b0;
    drive_enq(30, 0, 1, 1, 50, 0); tick();
    drive_enq(2, 1, 3, 1, 51, 1);  tick();
    drive_enq(31, 0, 1, 1, 52, 2); tick();
    drive_enq(32, 0, 1, 1, 53, 3); tick();
    drive_enq(4, 1, 0, 0, 54, 4);  tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_hold", io.iss_pd, 51);
    end
    io.iss_ready = 1'b1;
    tick();
    check("t5_second", io.iss_pd, 54);
    tick();
    check("t5_after", io.iss_valid, 0);
    drain();

`ifdef ALU_RS_FLUSH_EN
    io.iss_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_enq(33 + i, 0, 1, 1, 20 + i, i);
      tick();
    end
    drive_enq(1, 1, 2, 1, 60, 9);
    flush = 1'b1;
    #1;
    check("t6_flush_er", io.enq_ready, 0);
    check("t6_flush_iv", io.iss_valid, 0);
    tick();
    check("t6_empty_er", io.enq_ready, 1);
    check("t6_empty_iv", io.iss_valid, 0);
`endif

    // random traffic
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 9) < 6)
        drive_enq(($urandom_range(0, 7) == 0) ? 0
                    : $urandom_range(1, 15),
                  $urandom_range(0, 9) < 3,
                  ($urandom_range(0, 7) == 0) ? 0
                    : $urandom_range(1, 15),
                  $urandom_range(0, 9) < 3,
                  $urandom_range(0, 63), $urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        cdb($urandom_range(0, 15));
      io.iss_ready = $urandom_range(0, 9) < 7;
`ifdef ALU_RS_FLUSH_EN
      flush = $urandom_range(0, 49) == 0;
`endif
      tick();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
